sar_scheduler: RTL

SAR_SCHEDULER -- requirements
Module: sar_scheduler

---
 rtl/sar_scheduler_pkg.sv | 25 ++
 rtl/sar_scheduler_rr_arbiter.sv | 39 +++
 rtl/sar_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sar_scheduler_pkg.sv
// Shared types and constants for the SAR conversion scheduler.
// Holds the FSM encoding, the result width, the default timing parameters and the round-robin index helper.
package sar_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_HOLD      = 3'd5
    } sar_state_e;

    localparam int RES_W           = 16;
    localparam int DEFAULT_SETTLE  = 2;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam int SETTLE_CW       = 4;
    localparam int TIMEOUT_CW      = 8;

    // Channel index reached by stepping 'off' places past 'base', wrapping at n.
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/sar_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest-indexed requester strictly after last_grant.
// The search starts one past last_grant and wraps, so last_grant itself has the lowest priority.
module rr_arbiter
    import sar_scheduler_pkg::*;
#(
    parameter int NCH = 4,
    localparam int CW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  last_grant,
    output logic [CW-1:0]  grant,
    output logic           any
);

    logic [CW-1:0] grant_s;
    logic          any_s;
    logic [CW-1:0] idx_s;

    // Scan from the farthest offset down so the nearest requester overrides.
    always_comb begin
        grant_s = '0;
        any_s   = 1'b0;
        idx_s   = '0;
        for (int off = NCH; off >= 1; off--) begin
            idx_s = CW'(rr_index(int'(last_grant), off, NCH));
            if (req[idx_s]) begin
                grant_s = idx_s;
                any_s   = 1'b1;
            end else begin
                grant_s = grant_s;
                any_s   = any_s;
            end
        end
    end

    assign grant = grant_s;
    assign any   = any_s;

endmodule

// File: rtl/sar_scheduler.sv
// Round-robin scheduler for a shared SAR ADC: selects a channel, waits for the mux to settle,
// starts a conversion, captures the result and holds it until the consumer accepts it.
module sar_scheduler
    import sar_scheduler_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int SETTLE  = DEFAULT_SETTLE,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int CW     = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   ack,
    output logic [CW-1:0]    chan_sel,
    output logic             sar_go,
    input  logic             sar_valid,
    input  logic [RES_W-1:0] sar_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic [CW-1:0]    res_chan,
    output logic             busy,
    output logic             timeout_err
);

    localparam logic [SETTLE_CW-1:0]  SETTLE_LD  = SETTLE_CW'(SETTLE);
    localparam logic [TIMEOUT_CW-1:0] TIMEOUT_LD = TIMEOUT_CW'(TIMEOUT);
    localparam logic [NCH-1:0]        ONE_HOT0   = {{(NCH-1){1'b0}}, 1'b1};

    sar_state_e            state_r, state_nxt_s;
    logic [SETTLE_CW-1:0]  settle_r, settle_nxt_s;
    logic [TIMEOUT_CW-1:0] tmo_r, tmo_nxt_s;
    logic [CW-1:0]         last_grant_r;
    logic [CW-1:0]         chan_sel_r;
    logic [NCH-1:0]        ack_r;
    logic                  sar_go_r;
    logic                  busy_r;
    logic                  res_valid_r;
    logic [RES_W-1:0]      res_data_r;
    logic [CW-1:0]         res_chan_r;
    logic                  timeout_err_r;

    logic [CW-1:0]         grant_s;
    logic                  any_s;
    logic                  load_grant_s;
    logic                  capture_s;
    logic                  release_s;
    logic                  tmo_hit_s;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req        (req),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .any        (any_s)
    );

    // Next-state, counter and event decode for the conversion sequence.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        tmo_nxt_s    = tmo_r;
        load_grant_s = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        tmo_hit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    load_grant_s = 1'b1;
                    if (SETTLE == 0) begin
                        settle_nxt_s = '0;
                        state_nxt_s  = ST_START;
                    end else begin
                        settle_nxt_s = SETTLE_LD;
                        state_nxt_s  = ST_SETTLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_r <= 4'd1) begin
                    settle_nxt_s = '0;
                    state_nxt_s  = ST_START;
                end else begin
                    settle_nxt_s = settle_r - 4'd1;
                end
            end
            ST_START: begin
                tmo_nxt_s   = TIMEOUT_LD;
                state_nxt_s = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // A low sar_valid is the SAR's acknowledgement that it has started.
                if (!sar_valid) begin
                    tmo_nxt_s   = TIMEOUT_LD;
                    state_nxt_s = ST_WAIT_HIGH;
                end else if (tmo_r == 8'd0) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    tmo_nxt_s = tmo_r - 8'd1;
                end
            end
            ST_WAIT_HIGH: begin
                if (sar_valid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else if (tmo_r == 8'd0) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    tmo_nxt_s = tmo_r - 8'd1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    release_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                settle_nxt_s = '0;
                tmo_nxt_s    = '0;
            end
        endcase
    end

    // State, counters and registered outputs; sar_go and busy are decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            settle_r      <= '0;
            tmo_r         <= '0;
            last_grant_r  <= CW'(NCH - 1);
            chan_sel_r    <= '0;
            ack_r         <= '0;
            sar_go_r      <= 1'b0;
            busy_r        <= 1'b0;
            res_valid_r   <= 1'b0;
            res_data_r    <= '0;
            res_chan_r    <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            settle_r <= settle_nxt_s;
            tmo_r    <= tmo_nxt_s;
            sar_go_r <= (state_nxt_s == ST_START);
            busy_r   <= (state_nxt_s != ST_IDLE);
            ack_r    <= load_grant_s ? (ONE_HOT0 << grant_s) : '0;
            if (load_grant_s) begin
                chan_sel_r <= grant_s;
            end
            if (capture_s) begin
                res_data_r  <= sar_result;
                res_chan_r  <= chan_sel_r;
                res_valid_r <= 1'b1;
            end else if (release_s) begin
                res_valid_r <= 1'b0;
            end
            if (release_s || tmo_hit_s) begin
                last_grant_r <= chan_sel_r;
            end
            if (tmo_hit_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign ack         = ack_r;
    assign chan_sel    = chan_sel_r;
    assign sar_go      = sar_go_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_chan    = res_chan_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule
